// File: rtl/uart_rx_tx_cfg_if.sv
// Host-side bundle for uart_rx_tx_cfg: TX push port, RX valid/ready port and RX error flags.
// The UART itself is the slave; the host/wrapper logic is the master.
interface uart_rx_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] uart_tx_data;
  logic                 uart_tx_valid;
  logic                 uart_tx_ready;
  logic                 uart_tx_busy;
  logic [DATA_BITS-1:0] uart_received_data;
  logic                 uart_rx_valid;
  logic                 uart_rx_ready;
  logic                 uart_rx_parity_err;
  logic                 uart_rx_frame_err;
  logic                 uart_rx_overrun;
  logic                 err_clear;

  modport master (
    output uart_tx_data, uart_tx_valid, uart_rx_ready, err_clear,
    input  uart_tx_ready, uart_tx_busy, uart_received_data, uart_rx_valid,
           uart_rx_parity_err, uart_rx_frame_err, uart_rx_overrun
  );

  modport slave (
    input  uart_tx_data, uart_tx_valid, uart_rx_ready, err_clear,
    output uart_tx_ready, uart_tx_busy, uart_received_data, uart_rx_valid,
           uart_rx_parity_err, uart_rx_frame_err, uart_rx_overrun
  );
endinterface

// File: rtl/uart_rx_tx_cfg.sv
// Full-duplex UART with configurable data width, parity and stop bits.
// TX is fed from a small FIFO; RX presents words on a valid/ready port with error flags.
module uart_rx_tx_cfg #(
  parameter logic [27:0] CLOCK_FREQ    = 28'd100000000,
  parameter logic [23:0] BAUD_RATE     = 24'd9600,
  parameter int          DATA_BITS     = 8,
  parameter int          PARITY        = 0,
  parameter int          STOP_BITS     = 1,
  parameter int          TX_FIFO_DEPTH = 4
) (
  input  logic            clk_10ns,
  input  logic            uart_reset,
  uart_rx_tx_cfg_if.slave host,
  output logic            uart_tx_d_out,
  input  logic            uart_rx_d_in
);

  localparam int CLKS_PER_BIT = int'(CLOCK_FREQ) / int'(BAUD_RATE);
  localparam int CW = $clog2(2 * CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam int PW = $clog2(TX_FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(TX_FIFO_DEPTH);

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]          count_reg, count_next;
  logic                 tx_ready_reg;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  assign fifo_empty   = (count_reg == '0);
  assign push         = host.uart_tx_valid && tx_ready_reg;
  assign fifo_rd_data = fifo_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (PW + 1)'(1);
    else if (!push && pop)
      count_next = count_reg - (PW + 1)'(1);
  end

  always_ff @(posedge clk_10ns) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= host.uart_tx_data;
  end

  always_ff @(posedge clk_10ns) begin
    if (uart_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_ready_reg <= 1'b1;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg    <= count_next;
      tx_ready_reg <= (count_next != FIFO_FULL);
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state_reg, tx_state_next;
  logic [CW-1:0]        tx_cnt_reg;
  logic [BW-1:0]        tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 tx_line;
  logic                 tx_bit_end, tx_stop_end;

  assign tx_bit_end  = (tx_cnt_reg == BIT_LAST);
  assign tx_stop_end = (tx_cnt_reg == STOP_LAST);

  always_ff @(posedge clk_10ns) begin
    if (uart_reset)
      tx_state_reg <= TX_IDLE;
    else
      tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    unique case (tx_state_reg)
      TX_IDLE:   if (!fifo_empty) tx_state_next = TX_START;
      TX_START:  if (tx_bit_end) tx_state_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_bit_reg == DATA_LAST)
                   tx_state_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_state_next = TX_STOP;
      TX_STOP:   if (tx_stop_end) tx_state_next = fifo_empty ? TX_IDLE : TX_START;
      default:   tx_state_next = TX_IDLE;
    endcase
  end

  // A pop always coincides with entering START, from IDLE or straight out of STOP.
  always_comb begin
    pop     = 1'b0;
    tx_line = 1'b1;
    unique case (tx_state_reg)
      TX_IDLE:   pop = !fifo_empty;
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift_reg[0];
      TX_PARITY: tx_line = tx_par_reg;
      TX_STOP:   pop = tx_stop_end && !fifo_empty;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk_10ns) begin
    if (uart_reset) begin
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
    end else begin
      if (tx_state_next != tx_state_reg || (tx_state_reg == TX_DATA && tx_bit_end))
        tx_cnt_reg <= '0;
      else if (tx_state_reg != TX_IDLE)
        tx_cnt_reg <= tx_cnt_reg + CW'(1);

      if (pop) begin
        tx_shift_reg <= fifo_rd_data;
        tx_par_reg   <= (PARITY == 2) ? ^fifo_rd_data : ~^fifo_rd_data;
        tx_bit_reg   <= '0;
      end else if (tx_state_reg == TX_DATA && tx_bit_end) begin
        tx_shift_reg <= tx_shift_reg >> 1;
        tx_bit_reg   <= tx_bit_reg + BW'(1);
      end
    end
  end

  assign uart_tx_d_out      = tx_line;
  assign host.uart_tx_ready = tx_ready_reg;
  assign host.uart_tx_busy  = (tx_state_reg != TX_IDLE) || !fifo_empty;

  // ---------------- RX path ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  rx_state_t            rx_state_reg, rx_state_next;
  logic                 rx_meta_reg, rx_sync_reg;
  logic [CW-1:0]        rx_cnt_reg;
  logic [BW-1:0]        rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_par_bit_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, rx_perr_reg, rx_ferr_reg, rx_overrun_reg;
  logic                 rx_bit_end, rx_half_end;
  logic                 rx_shift_en, rx_par_en, rx_stop_sample;
  logic                 rx_load, rx_overrun_set;
  logic                 rx_exp_par, rx_perr_new;

  assign rx_bit_end  = (rx_cnt_reg == BIT_LAST);
  assign rx_half_end = (rx_cnt_reg == HALF_LAST);

  always_ff @(posedge clk_10ns) begin
    if (uart_reset)
      rx_state_reg <= RX_IDLE;
    else
      rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    unique case (rx_state_reg)
      RX_IDLE:      if (!rx_sync_reg) rx_state_next = RX_START;
      RX_START:     if (rx_half_end) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_bit_end && rx_bit_reg == DATA_LAST)
                      rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_bit_end) rx_state_next = RX_STOP;
      RX_STOP:      if (rx_bit_end) rx_state_next = rx_sync_reg ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_sync_reg) rx_state_next = RX_IDLE;
      default:      rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_en    = (rx_state_reg == RX_DATA)   && rx_bit_end;
    rx_par_en      = (rx_state_reg == RX_PARITY) && rx_bit_end;
    rx_stop_sample = (rx_state_reg == RX_STOP)   && rx_bit_end;
    rx_load        = rx_stop_sample && (!rx_valid_reg || host.uart_rx_ready);
    rx_overrun_set = rx_stop_sample && rx_valid_reg && !host.uart_rx_ready;
  end

  assign rx_exp_par  = (PARITY == 2) ? ^rx_shift_reg : ~^rx_shift_reg;
  assign rx_perr_new = (PARITY != 0) && (rx_par_bit_reg != rx_exp_par);

  always_ff @(posedge clk_10ns) begin
    if (uart_reset) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_bit_reg <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_perr_reg    <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rx_meta_reg <= uart_rx_d_in;
      rx_sync_reg <= rx_meta_reg;

      if (rx_state_next != rx_state_reg || rx_shift_en)
        rx_cnt_reg <= '0;
      else if (rx_state_reg != RX_IDLE && rx_state_reg != RX_WAIT_HIGH)
        rx_cnt_reg <= rx_cnt_reg + CW'(1);

      if (rx_state_reg == RX_IDLE)
        rx_bit_reg <= '0;
      else if (rx_shift_en) begin
        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
        rx_bit_reg   <= rx_bit_reg + BW'(1);
      end

      if (rx_par_en)
        rx_par_bit_reg <= rx_sync_reg;

      // A full holding register keeps its word and flags; the new frame only marks overrun.
      if (rx_load) begin
        rx_data_reg  <= rx_shift_reg;
        rx_perr_reg  <= rx_perr_new;
        rx_ferr_reg  <= !rx_sync_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && host.uart_rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      if (rx_overrun_set)
        rx_overrun_reg <= 1'b1;
      else if (host.err_clear)
        rx_overrun_reg <= 1'b0;
    end
  end

  assign host.uart_received_data = rx_data_reg;
  assign host.uart_rx_valid      = rx_valid_reg;
  assign host.uart_rx_parity_err = rx_perr_reg;
  assign host.uart_rx_frame_err  = rx_ferr_reg;
  assign host.uart_rx_overrun    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_rx_tx_cfg.sv
// Self-checking bench for uart_rx_tx_cfg: three configurations (8N1, 7E2 loopback, 8O1 with depth 2)
// exercised with table vectors, directed corner sequences and randomized frames against a frame-level model.
module tb_uart_rx_tx_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic inj_line;
  int   inj_sel;
  logic rx_a, rx_c, tx_a, tx_b, tx_c;
  int   checks = 0;
  int   errors = 0;

  assign rx_a = (inj_sel == 0) ? inj_line : 1'b1;
  assign rx_c = (inj_sel == 2) ? inj_line : 1'b1;

  uart_rx_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_tx_cfg_if #(.DATA_BITS(7)) if_b ();
  uart_rx_tx_cfg_if #(.DATA_BITS(8)) if_c ();

  uart_rx_tx_cfg #(.CLOCK_FREQ(28'd1600), .BAUD_RATE(24'd100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .TX_FIFO_DEPTH(4))
    dut_a (.clk_10ns(clk), .uart_reset(rst), .host(if_a), .uart_tx_d_out(tx_a), .uart_rx_d_in(rx_a));

  uart_rx_tx_cfg #(.CLOCK_FREQ(28'd1600), .BAUD_RATE(24'd100), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .TX_FIFO_DEPTH(4))
    dut_b (.clk_10ns(clk), .uart_reset(rst), .host(if_b), .uart_tx_d_out(tx_b), .uart_rx_d_in(tx_b));

  uart_rx_tx_cfg #(.CLOCK_FREQ(28'd1600), .BAUD_RATE(24'd100), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .TX_FIFO_DEPTH(2))
    dut_c (.clk_10ns(clk), .uart_reset(rst), .host(if_c), .uart_tx_d_out(tx_c), .uart_rx_d_in(rx_c));

  typedef struct {
    logic [7:0] data;
    logic       exp_ready;
  } push_vec_t;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } rx_vec_t;

  push_vec_t pv [6];
  rx_vec_t   rv [4];
  int        qexp [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: bit k of a frame (0 = start), LSB-first data, optional parity, then stop.
  function automatic int frame_bit(input int data, input int nbits, input int par, input int k);
    int ones;
    ones = 0;
    if (k == 0) return 0;
    if (k <= nbits) return (data >> (k - 1)) & 1;
    if (par != 0 && k == nbits + 1) begin
      for (int i = 0; i < nbits; i++) ones += (data >> i) & 1;
      return (par == 2) ? (ones % 2) : (1 - (ones % 2));
    end
    return 1;
  endfunction

  task automatic check_frame_a(input int data, input string tag);
    int   bad;
    logic eb;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      eb  = (frame_bit(data, 8, 0, k) != 0);
      for (int j = 0; j < CPB; j++) begin
        if (tx_a !== eb) bad++;
        tick();
      end
      check($sformatf("%s_bit%0d_badcycles", tag, k), bad, 0);
    end
    $display("tx frame %s data=%02h checked", tag, data);
  endtask

  task automatic wait_tx_a_low(input int limit, input string tag);
    int n;
    n = 0;
    while (tx_a !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) check({tag, "_start_timeout"}, 1, 0);
  endtask

  task automatic inject(input int data, input int nbits, input int par, input bit bad_par, input bit stop_val);
    int nb;
    int b;
    nb = nbits + ((par != 0) ? 1 : 0) + 2;
    for (int k = 0; k < nb; k++) begin
      b = frame_bit(data, nbits, par, k);
      if (par != 0 && k == nbits + 1 && bad_par) b = 1 - b;
      if (k == nb - 1) b = stop_val ? 1 : 0;
      inj_line = (b != 0);
      repeat (CPB) tick();
    end
  endtask

  task automatic consume_c();
    if_c.uart_rx_ready = 1'b1;
    tick();
    if_c.uart_rx_ready = 1'b0;
  endtask

  initial begin : main
    int d, got, cyc, exp_word;
    bit bp, st;

    pv[0] = '{8'h11, 1'b1}; pv[1] = '{8'h22, 1'b1}; pv[2] = '{8'h33, 1'b1};
    pv[3] = '{8'h44, 1'b1}; pv[4] = '{8'h55, 1'b1}; pv[5] = '{8'h66, 1'b0};
    rv[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    rv[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    rv[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    rv[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1; inj_line = 1'b1; inj_sel = 0;
    if_a.uart_tx_data = '0; if_a.uart_tx_valid = 1'b0; if_a.uart_rx_ready = 1'b0; if_a.err_clear = 1'b0;
    if_b.uart_tx_data = '0; if_b.uart_tx_valid = 1'b0; if_b.uart_rx_ready = 1'b0; if_b.err_clear = 1'b0;
    if_c.uart_tx_data = '0; if_c.uart_tx_valid = 1'b0; if_c.uart_rx_ready = 1'b0; if_c.err_clear = 1'b0;
    repeat (3) tick();
    check("rst_tx_line", tx_a, 1);
    check("rst_tx_ready", if_a.uart_tx_ready, 1);
    check("rst_tx_busy", if_a.uart_tx_busy, 0);
    check("rst_rx_valid", if_a.uart_rx_valid, 0);
    check("rst_rx_data", if_a.uart_received_data, 0);
    check("rst_flags", {if_a.uart_rx_parity_err, if_a.uart_rx_frame_err, if_a.uart_rx_overrun}, 0);
    rst = 1'b0;
    repeat (4) tick();

    // 8N1 single frame: exact push-to-start latency and waveform
    if_a.uart_tx_data = 8'hA5; if_a.uart_tx_valid = 1'b1;
    tick();
    if_a.uart_tx_valid = 1'b0;
    check("t1_line_idle_after_push", tx_a, 1);
    check("t1_busy_after_push", if_a.uart_tx_busy, 1);
    tick();
    check_frame_a(8'hA5, "t1");
    check("t1_line_after_stop", tx_a, 1);
    check("t1_busy_after_stop", if_a.uart_tx_busy, 0);

    // FIFO fill: 6 pushes, 5 accepted, frames back-to-back
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if_a.uart_tx_data = pv[i].data; if_a.uart_tx_valid = 1'b1;
          check($sformatf("t3_ready_%0d", i), if_a.uart_tx_ready, pv[i].exp_ready);
          $display("push %0d data=%02h ready=%0b", i, pv[i].data, if_a.uart_tx_ready);
          tick();
        end
        if_a.uart_tx_valid = 1'b0;
      end
      begin
        wait_tx_a_low(10, "t3");
        for (int i = 0; i < 6; i++)
          if (pv[i].exp_ready) check_frame_a(pv[i].data, $sformatf("t3_f%0d", i));
      end
    join
    check("t3_line_after_burst", tx_a, 1);
    check("t3_busy_after_burst", if_a.uart_tx_busy, 0);

    // RX overrun on dut_a
    inj_sel = 0;
    inject(8'h12, 8, 0, 1'b0, 1'b1);
    check("t4_valid_first", if_a.uart_rx_valid, 1);
    check("t4_data_first", if_a.uart_received_data, 8'h12);
    check("t4_overrun_first", if_a.uart_rx_overrun, 0);
    inject(8'h34, 8, 0, 1'b0, 1'b1);
    check("t4_data_kept", if_a.uart_received_data, 8'h12);
    check("t4_overrun_set", if_a.uart_rx_overrun, 1);
    if_a.err_clear = 1'b1;
    tick();
    if_a.err_clear = 1'b0;
    check("t4_overrun_cleared", if_a.uart_rx_overrun, 0);
    if_a.uart_rx_ready = 1'b1;
    tick();
    if_a.uart_rx_ready = 1'b0;
    check("t4_valid_drained", if_a.uart_rx_valid, 0);
    $display("rx overrun sequence done");

    // RX table vectors on dut_c (odd parity)
    inj_sel = 2;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      inject(rv[i].data, 8, 1, rv[i].bad_par, rv[i].stop);
      check($sformatf("t5_vec%0d_valid", i), if_c.uart_rx_valid, 1);
      check($sformatf("t5_vec%0d_data", i), if_c.uart_received_data, rv[i].exp_data);
      check($sformatf("t5_vec%0d_perr", i), if_c.uart_rx_parity_err, rv[i].exp_perr);
      check($sformatf("t5_vec%0d_ferr", i), if_c.uart_rx_frame_err, rv[i].exp_ferr);
      $display("rx vec %0d data=%02h perr=%0b ferr=%0b", i, if_c.uart_received_data,
               if_c.uart_rx_parity_err, if_c.uart_rx_frame_err);
      consume_c();
      check($sformatf("t5_vec%0d_cleared", i), if_c.uart_rx_valid, 0);
    end

    // Break: stop bit low then 40 more low cycles
    inject(8'h81, 8, 1, 1'b0, 1'b0);
    check("t5_break_valid", if_c.uart_rx_valid, 1);
    check("t5_break_ferr", if_c.uart_rx_frame_err, 1);
    check("t5_break_perr", if_c.uart_rx_parity_err, 0);
    consume_c();
    repeat (39) tick();
    check("t5_break_low_no_word", if_c.uart_rx_valid, 0);
    inj_line = 1'b1;
    repeat (250) tick();
    check("t5_break_no_spurious", if_c.uart_rx_valid, 0);
    inject(8'h5A, 8, 1, 1'b0, 1'b1);
    check("t5_recover_data", if_c.uart_received_data, 8'h5A);
    check("t5_recover_flags", {if_c.uart_rx_valid, if_c.uart_rx_parity_err, if_c.uart_rx_frame_err}, 3'b100);
    consume_c();

    // Randomized RX frames on dut_c against the frame model
    for (int i = 0; i < 8; i++) begin
      d  = $urandom_range(0, 255);
      bp = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) != 0);
      inject(d, 8, 1, bp, st);
      inj_line = 1'b1;
      check($sformatf("rnd_c%0d_valid", i), if_c.uart_rx_valid, 1);
      check($sformatf("rnd_c%0d_data", i), if_c.uart_received_data, d);
      check($sformatf("rnd_c%0d_perr", i), if_c.uart_rx_parity_err, bp);
      check($sformatf("rnd_c%0d_ferr", i), if_c.uart_rx_frame_err, !st);
      $display("rnd rx %0d data=%02h bad_par=%0b stop=%0b", i, d, bp, st);
      consume_c();
      repeat (20) tick();
    end

    // Glitch rejection on dut_a
    inj_sel = 0;
    inj_line = 1'b0;
    repeat (5) tick();
    inj_line = 1'b1;
    repeat (200) tick();
    check("t6_glitch_no_valid", if_a.uart_rx_valid, 0);

    // Reset mid TX frame, FIFO still holding words
    for (int i = 0; i < 3; i++) begin
      if_a.uart_tx_data = (i == 0) ? 8'hA5 : 8'h11 * i; if_a.uart_tx_valid = 1'b1;
      tick();
    end
    if_a.uart_tx_valid = 1'b0;
    wait_tx_a_low(10, "t6");
    repeat (69) tick();
    check("t6_line_low_bit3", tx_a, 0);
    rst = 1'b1;
    tick();
    check("t6_line_after_reset", tx_a, 1);
    check("t6_ready_after_reset", if_a.uart_tx_ready, 1);
    check("t6_busy_after_reset", if_a.uart_tx_busy, 0);
    rst = 1'b0;
    repeat (40) tick();
    check("t6_still_idle", {tx_a, if_a.uart_tx_busy}, 2'b10);
    $display("reset-mid-frame sequence done");

    // Loopback 7E2: hold word until consumer ready
    if_b.uart_rx_ready = 1'b0;
    if_b.uart_tx_data = 7'h55; if_b.uart_tx_valid = 1'b1;
    tick();
    if_b.uart_tx_valid = 1'b0;
    cyc = 0;
    while (if_b.uart_rx_valid !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("t2_valid", if_b.uart_rx_valid, 1);
    check("t2_data", if_b.uart_received_data, 7'h55);
    check("t2_perr", if_b.uart_rx_parity_err, 0);
    check("t2_ferr", if_b.uart_rx_frame_err, 0);
    repeat (50) tick();
    check("t2_valid_held", if_b.uart_rx_valid, 1);
    if_b.uart_rx_ready = 1'b1;
    tick();
    if_b.uart_rx_ready = 1'b0;
    check("t2_valid_cleared", if_b.uart_rx_valid, 0);

    // Randomized loopback traffic with scoreboard
    got = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          d = $urandom_range(0, 127);
          if_b.uart_tx_data = 7'(d); if_b.uart_tx_valid = 1'b1;
          for (int w = 0; w < 2000; w++) begin
            if (if_b.uart_tx_ready === 1'b1) begin
              qexp.push_back(d);
              tick();
              break;
            end
            tick();
          end
          if_b.uart_tx_valid = 1'b0;
          repeat ($urandom_range(0, 200)) tick();
        end
      end
      begin
        cyc = 0;
        while (got < 12 && cyc < 9000) begin
          if_b.uart_rx_ready = ($urandom_range(0, 1) == 1);
          if (if_b.uart_rx_ready && if_b.uart_rx_valid === 1'b1) begin
            exp_word = (qexp.size() > 0) ? qexp.pop_front() : -1;
            check($sformatf("loop%0d_data", got), if_b.uart_received_data, exp_word);
            check($sformatf("loop%0d_flags", got), {if_b.uart_rx_parity_err, if_b.uart_rx_frame_err}, 0);
            $display("loopback %0d data=%02h expected=%02h", got, if_b.uart_received_data, exp_word);
            got++;
          end
          tick();
          cyc++;
        end
        if_b.uart_rx_ready = 1'b0;
      end
    join
    check("loop_word_count", got, 12);
    check("loop_no_overrun", if_b.uart_rx_overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
